demux4x32_buf: RTL and testbench
================================

DEMUX4X32_BUF -- requirements
Module: demux4x32_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32: data width of the input and of each output lane.
REQ-002 SHALL have parameter DEPTH, default 2: entries per output FIFO; power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port a, input, WIDTH: input data word.
REQ-006 SHALL have port s, input, 2: destination lane select (0..3), sampled with a.
REQ-007 SHALL have port in_valid, input, 1: a and s are valid this cycle.
REQ-008 SHALL have port in_ready, output, 1: block accepts the word this cycle.
REQ-009 SHALL have ports y0, y1, y2 and y3, each output, WIDTH: head-of-FIFO data of lanes 0..3.
REQ-010 SHALL have port y_valid, output, 4: bit k set means yk holds a valid word.
REQ-011 SHALL have port y_ready, input, 4: bit k set means the consumer of lane k takes yk this cycle.
REQ-012 SHALL have ports occ0, occ1, occ2 and occ3, each output, log2(DEPTH)+1 bits: current entry count of lanes 0..3.

Function
REQ-013 SHALL compute in_ready combinationally as NOT full[s], where full[k] means occk == DEPTH.
REQ-014 SHALL push a into FIFO s on a rising edge when in_valid and in_ready are both 1 (input transfer).
REQ-015 SHALL never write any FIFO other than FIFO s; the other lanes keep their contents.
REQ-016 SHALL pop the head of FIFO k on a rising edge when y_valid[k] and y_ready[k] are both 1 (lane-k transfer).
REQ-017 SHALL allow all four lanes to pop independently in the same cycle.
REQ-018 SHALL drive y_valid[k] = (occk != 0) directly from registered state, so it does not depend combinationally on any input.
REQ-019 SHALL drive yk with the head entry of FIFO k when occk != 0, and with all zeros when occk == 0.
REQ-020 SHALL have latency of 1 cycle: a word accepted at edge N appears on yk with y_valid[k]=1 after edge N if FIFO k was empty.
REQ-021 SHALL preserve FIFO order within each lane; there is no ordering guarantee between lanes.
REQ-022 SHALL, on a same-cycle push and pop on one non-full lane, write the new word and retire the head, leaving occk unchanged.
REQ-023 SHALL, on a same-cycle pop on a full lane, still hold in_ready low for that lane; there is no bypass or pass-through.
REQ-024 SHALL, on a same-cycle push and pop on an empty lane, perform the push only, since y_valid=0 and no pop occurs; occk becomes 1.
REQ-025 SHALL use read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH with no lost or duplicated entry at wrap-around.
REQ-026 SHALL ignore in_valid=0 regardless of s and a, and SHALL ignore y_ready[k] while y_valid[k]=0.
REQ-027 SHALL NOT change occk, pointers or the head data while no transfer occurs on lane k.

Reset
REQ-028 SHALL, while rst=1, clear all pointers and occ0..occ3 to 0 immediately and asynchronously, giving y_valid=4'b0000, y0..y3=0, and in_ready=1.
REQ-029 SHALL discard all buffered words on reset asserted mid-operation, including a transfer coincident with the edge; FIFO storage contents need not be cleared.
REQ-030 SHALL accept a push on the first rising edge after rst deasserts.

Verification
REQ-031 SHALL cover basic routing: after reset, push a=32'hA5A5_0001 with s=2 and all y_ready=0 -> next cycle y_valid=4'b0100, y2=32'hA5A5_0001, occ2=1, and y0/y1/y3=0.
REQ-032 SHALL cover full lane: push 32'h1 then 32'h2 to s=1 with y_ready=0 -> occ1=2, and in_ready=0 while s=1 but in_ready=1 for s=0; a third push at s=1 is not stored.
REQ-033 SHALL cover order and wrap: stream 32'h10..32'h17 into s=3 with y_ready[3]=1 -> y3 shows 10..17 in order, no gaps or duplicates, and occ3 never exceeds 2.
REQ-034 SHALL cover simultaneous push and pop: with occ0=1 (head 32'hC0), push 32'hC1 to s=0 while y_ready[0]=1 -> next cycle y0=32'hC1 and occ0=1.
REQ-035 SHALL cover parallel drain: fill lanes 0..3 with one word each, then set y_ready=4'b1111 for one cycle -> all occ=0 and y_valid=4'b0000 next cycle.
REQ-036 SHALL cover reset mid-operation: with occ2=2, assert rst between edges -> y_valid=0 and occ2=0 immediately, and in_ready=1 for every s.

Source files
------------

// File: rtl/demux4x32_buf.sv
// Four-lane demultiplexer with a small FIFO per output lane.
// The word on `a` is routed to lane `s`; each lane drains independently under valid/ready.

module demux4x32_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         a,
    input  logic [1:0]               s,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         y0,
    output logic [WIDTH-1:0]         y1,
    output logic [WIDTH-1:0]         y2,
    output logic [WIDTH-1:0]         y3,
    output logic [3:0]               y_valid,
    input  logic [3:0]               y_ready,
    output logic [$clog2(DEPTH):0]   occ0,
    output logic [$clog2(DEPTH):0]   occ1,
    output logic [$clog2(DEPTH):0]   occ2,
    output logic [$clog2(DEPTH):0]   occ3
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [3:0]            w_push;
    logic [3:0]            w_pop;
    logic [3:0]            w_full;
    logic [3:0][WIDTH-1:0] w_head;
    logic [3:0][AW:0]      w_occ;

    // A full lane refuses input even if it pops this cycle: no pass-through path.
    assign in_ready = ~w_full[s];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]    r_wr_ptr;
        logic [AW-1:0]    r_rd_ptr;
        logic [AW:0]      r_occ;

        assign w_full[k] = (r_occ == OCC_FULL);
        assign w_push[k] = in_valid && !w_full[k] && (s == 2'(k));
        assign w_pop[k]  = (r_occ != '0) && y_ready[k];

        // NOTE: storage is deliberately not reset; r_occ alone decides which entries are live.
        always_ff @(posedge clk) begin
            if (w_push[k]) begin
                r_mem[r_wr_ptr] <= a;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push[k]) begin
                    r_wr_ptr <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop[k]) begin
                    r_rd_ptr <= r_rd_ptr + PTR_ONE;
                end
                case ({w_push[k], w_pop[k]})
                    2'b10:   r_occ <= r_occ + OCC_ONE;
                    2'b01:   r_occ <= r_occ - OCC_ONE;
                    default: r_occ <= r_occ;
                endcase
            end
        end

        assign w_occ[k]   = r_occ;
        assign w_head[k]  = (r_occ != '0) ? r_mem[r_rd_ptr] : '0;
        assign y_valid[k] = (r_occ != '0);
    end

    assign y0   = w_head[0];
    assign y1   = w_head[1];
    assign y2   = w_head[2];
    assign y3   = w_head[3];
    assign occ0 = w_occ[0];
    assign occ1 = w_occ[1];
    assign occ2 = w_occ[2];
    assign occ3 = w_occ[3];

endmodule

// File: tb/tb_demux4x32_buf.sv
// Directed bench for demux4x32_buf: inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that acted on them.

module tb_demux4x32_buf;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [1:0]  s;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] y0, y1, y2, y3;
    logic [3:0]  y_valid;
    logic [3:0]  y_ready;
    logic [1:0]  occ0, occ1, occ2, occ3;

    int n_pass  = 0;
    int n_total = 0;

    demux4x32_buf #(.WIDTH(32), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .s        (s),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y0       (y0),
        .y1       (y1),
        .y2       (y2),
        .y3       (y3),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .occ0     (occ0),
        .occ1     (occ1),
        .occ2     (occ2),
        .occ3     (occ3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        n_total++;
        if (y_valid !== 4'b0000) $display("FAIL reset_y_valid: got %b expected 0000", y_valid);
        else n_pass++;
        n_total++;
        if ({occ0, occ1, occ2, occ3} !== 8'h00) $display("FAIL reset_occ: got %h expected 00", {occ0, occ1, occ2, occ3});
        else n_pass++;
        n_total++;
        if ({y0, y1, y2, y3} !== 128'h0) $display("FAIL reset_y: got %h expected 0", {y0, y1, y2, y3});
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_routing;
        a = 32'hA5A5_0001; s = 2'd2; in_valid = 1'b1; y_ready = 4'b0000;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (y_valid !== 4'b0100) $display("FAIL route_y_valid: got %b expected 0100", y_valid);
        else n_pass++;
        n_total++;
        if (y2 !== 32'hA5A5_0001) $display("FAIL route_y2: got %h expected a5a50001", y2);
        else n_pass++;
        n_total++;
        if (occ2 !== 2'd1) $display("FAIL route_occ2: got %0d expected 1", occ2);
        else n_pass++;
        n_total++;
        if ({y0, y1, y3} !== 96'h0) $display("FAIL route_other_lanes: got %h expected 0", {y0, y1, y3});
        else n_pass++;
        y_ready = 4'b0100;
        tick();
        y_ready = 4'b0000;
        n_total++;
        if (occ2 !== 2'd0) $display("FAIL route_drain_occ2: got %0d expected 0", occ2);
        else n_pass++;
    endtask

    task automatic test_full_lane;
        s = 2'd1; in_valid = 1'b1; y_ready = 4'b0000;
        a = 32'h1; tick();
        a = 32'h2; tick();
        in_valid = 1'b0; #1;
        n_total++;
        if (occ1 !== 2'd2) $display("FAIL full_occ1: got %0d expected 2", occ1);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL full_in_ready_s1: got %b expected 0", in_ready);
        else n_pass++;
        s = 2'd0; #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL full_in_ready_s0: got %b expected 1", in_ready);
        else n_pass++;
        s = 2'd1; a = 32'h3; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (occ1 !== 2'd2 || y1 !== 32'h1) $display("FAIL full_third_push: got occ1=%0d y1=%h expected occ1=2 y1=1", occ1, y1);
        else n_pass++;
        y_ready = 4'b0010;
        tick();
        n_total++;
        if (y1 !== 32'h2 || occ1 !== 2'd1) $display("FAIL full_pop1: got y1=%h occ1=%0d expected y1=2 occ1=1", y1, occ1);
        else n_pass++;
        tick();
        y_ready = 4'b0000;
        n_total++;
        if (y_valid !== 4'b0000 || occ1 !== 2'd0) $display("FAIL full_pop2: got y_valid=%b occ1=%0d expected 0000/0", y_valid, occ1);
        else n_pass++;
    endtask

    task automatic test_order_wrap;
        int exp_idx  = 0;
        int push_idx = 0;
        s = 2'd3;
        for (int cyc = 0; cyc < 40 && exp_idx < 8; cyc++) begin
            y_ready = (cyc % 3 != 2) ? 4'b1000 : 4'b0000;
            if (y_valid[3]) begin
                n_total++;
                if (y3 !== 32'h10 + 32'(exp_idx)) $display("FAIL order_y3: got %h expected %h", y3, 32'h10 + 32'(exp_idx));
                else n_pass++;
                if (y_ready[3]) exp_idx++;
            end
            n_total++;
            if (occ3 > 2'd2) $display("FAIL order_occ3_bound: got %0d expected <=2", occ3);
            else n_pass++;
            if (push_idx < 8) begin
                in_valid = 1'b1;
                a = 32'h10 + 32'(push_idx);
                #1;
                if (in_ready) push_idx++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0; y_ready = 4'b0000;
        n_total++;
        if (exp_idx !== 8 || occ3 !== 2'd0) $display("FAIL order_complete: got popped=%0d occ3=%0d expected 8/0", exp_idx, occ3);
        else n_pass++;
    endtask

    task automatic test_push_pop;
        s = 2'd0; a = 32'hC0; in_valid = 1'b1; y_ready = 4'b0000;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (occ0 !== 2'd1 || y0 !== 32'hC0) $display("FAIL pp_setup: got occ0=%0d y0=%h expected 1/c0", occ0, y0);
        else n_pass++;
        a = 32'hC1; in_valid = 1'b1; y_ready = 4'b0001;
        tick();
        in_valid = 1'b0;
        n_total++;
        if (y0 !== 32'hC1 || occ0 !== 2'd1) $display("FAIL pp_same_cycle: got y0=%h occ0=%0d expected c1/1", y0, occ0);
        else n_pass++;
        tick();
        n_total++;
        if (occ0 !== 2'd0) $display("FAIL pp_drain: got occ0=%0d expected 0", occ0);
        else n_pass++;
        // Push and pop on an empty lane: only the push takes effect.
        a = 32'hE0; in_valid = 1'b1; y_ready = 4'b0001;
        tick();
        in_valid = 1'b0; y_ready = 4'b0000;
        n_total++;
        if (occ0 !== 2'd1 || y0 !== 32'hE0) $display("FAIL pp_empty_lane: got occ0=%0d y0=%h expected 1/e0", occ0, y0);
        else n_pass++;
        a = 32'hE1; in_valid = 1'b1;
        tick();
        // Pop on a full lane still refuses the new word.
        a = 32'hE2; y_ready = 4'b0001; #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL pp_full_in_ready: got %b expected 0", in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0; y_ready = 4'b0000;
        n_total++;
        if (occ0 !== 2'd1 || y0 !== 32'hE1) $display("FAIL pp_full_pop: got occ0=%0d y0=%h expected 1/e1", occ0, y0);
        else n_pass++;
        y_ready = 4'b0001;
        tick();
        y_ready = 4'b0000;
        n_total++;
        if (y_valid[0] !== 1'b0 || y0 !== 32'h0) $display("FAIL pp_empty_zero: got valid=%b y0=%h expected 0/0", y_valid[0], y0);
        else n_pass++;
    endtask

    task automatic test_parallel_drain;
        in_valid = 1'b1; y_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k); a = 32'hD0 + 32'(k);
            tick();
        end
        in_valid = 1'b0;
        n_total++;
        if (y_valid !== 4'b1111 || {y0, y1, y2, y3} !== {32'hD0, 32'hD1, 32'hD2, 32'hD3})
            $display("FAIL drain_fill: got valid=%b y=%h %h %h %h expected 1111 d0 d1 d2 d3", y_valid, y0, y1, y2, y3);
        else n_pass++;
        y_ready = 4'b1111;
        tick();
        y_ready = 4'b0000;
        n_total++;
        if (y_valid !== 4'b0000 || {occ0, occ1, occ2, occ3} !== 8'h00)
            $display("FAIL drain_all: got valid=%b occ=%h expected 0000/00", y_valid, {occ0, occ1, occ2, occ3});
        else n_pass++;
    endtask

    task automatic test_ignore;
        in_valid = 1'b0; s = 2'd1; a = 32'hDEAD_BEEF; y_ready = 4'b1111;
        tick();
        y_ready = 4'b0000;
        n_total++;
        if (y_valid !== 4'b0000 || {occ0, occ1, occ2, occ3} !== 8'h00)
            $display("FAIL ignore_idle: got valid=%b occ=%h expected 0000/00", y_valid, {occ0, occ1, occ2, occ3});
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        s = 2'd2; in_valid = 1'b1; y_ready = 4'b0000;
        a = 32'hF0; tick();
        a = 32'hF1; tick();
        n_total++;
        if (occ2 !== 2'd2) $display("FAIL rmid_setup: got occ2=%0d expected 2", occ2);
        else n_pass++;
        // Leave a push request pending across the reset edge; it must be dropped.
        rst = 1'b1; #1;
        n_total++;
        if (y_valid !== 4'b0000 || occ2 !== 2'd0 || y2 !== 32'h0)
            $display("FAIL rmid_async: got valid=%b occ2=%0d y2=%h expected 0000/0/0", y_valid, occ2, y2);
        else n_pass++;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s = 2'(k); #1;
            n_total++;
            if (in_ready !== 1'b1) $display("FAIL rmid_in_ready_s%0d: got %b expected 1", k, in_ready);
            else n_pass++;
        end
        s = 2'd2; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; rst = 1'b0;
        tick();
        n_total++;
        if (occ2 !== 2'd0 || y_valid !== 4'b0000) $display("FAIL rmid_after: got occ2=%0d valid=%b expected 0/0000", occ2, y_valid);
        else n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; a = '0; s = '0; in_valid = 1'b0; y_ready = 4'b0000;
        @(negedge clk);
        #1;
        test_reset();
        tick();
        rst = 1'b0;
        test_routing();
        test_full_lane();
        test_order_wrap();
        test_push_pop();
        test_parallel_drain();
        test_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
